// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads a 32-bit instruction as four
// little-endian byte reads over a req/ack port, and presents it to the decoder
// under a valid/ready handshake. The controller can redirect the PC at any time.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic [2:0] {
        StFetch0,
        StFetch1,
        StFetch2,
        StFetch3,
        StHold
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;

    // Byte index being fetched and the state that follows its acknowledge.
    logic [1:0] byte_idx;
    state_e     fetch_next;

    // Decode the current fetch slot from the registered state.
    always_comb begin
        byte_idx   = 2'd0;
        fetch_next = StFetch1;
        unique case (state_q)
            StFetch0: begin byte_idx = 2'd0; fetch_next = StFetch1; end
            StFetch1: begin byte_idx = 2'd1; fetch_next = StFetch2; end
            StFetch2: begin byte_idx = 2'd2; fetch_next = StFetch3; end
            StFetch3: begin byte_idx = 2'd3; fetch_next = StHold;   end
            StHold:   begin byte_idx = 2'd0; fetch_next = StFetch0; end
            default:  begin byte_idx = 2'd0; fetch_next = StFetch0; end
        endcase
    end

    // Next-state logic: redirect beats the decoder handshake, which beats mem_ack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (pc_load) begin
            // Partial bytes and any same-cycle ack are dropped; the held word too.
            pc_d    = pc_next;
            state_d = StFetch0;
        end else if (state_q == StHold) begin
            if (instr_ready) begin
                pc_d    = pc_q + ADDR_WIDTH'(4);
                state_d = StFetch0;
            end
        end else if (mem_ack) begin
            instr_d[{byte_idx, 3'b000} +: 8] = mem_rdata;
            state_d                          = fetch_next;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch0;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs depend only on registered state (request is masked during reset).
    always_comb begin
        mem_req     = (state_q != StHold) && !reset;
        mem_addr    = pc_q + ADDR_WIDTH'(byte_idx);
        instr       = instr_q;
        instr_valid = (state_q == StHold);
        pc          = pc_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level model (PC plus bytes collected).
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: RESET_PC = 0
    logic        reset, mem_req, mem_ack, instr_valid, instr_ready, pc_load;
    logic [7:0]  mem_addr, mem_rdata, pc_next, pc;
    logic [31:0] instr;
    // DUT B: RESET_PC = 8'hFC
    logic        b_reset, b_mem_req, b_mem_ack, b_instr_valid, b_instr_ready, b_pc_load;
    logic [7:0]  b_mem_addr, b_mem_rdata, b_pc_next, b_pc;
    logic [31:0] b_instr;

    logic [7:0] mem [256];
    assign mem_rdata   = mem[mem_addr];
    assign b_mem_rdata = mem[b_mem_addr];

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_load(pc_load),
        .pc_next(pc_next), .pc(pc)
    );

    instr_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'hFC)) u_dut_wrap (
        .clk(clk), .reset(b_reset), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .instr(b_instr),
        .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .pc_load(b_pc_load),
        .pc_next(b_pc_next), .pc(b_pc)
    );

    // Little-endian word starting at byte address a, wrapping at 256.
    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in the first cycle after reset release (FETCH0, pc = 0).
    task automatic do_reset();
        reset       = 1'b1;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        pc_next     = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        pc_load     = 1'b0;
        pc_next     = 8'h00;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++;
            $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got=%b want=0", instr_valid); end
        checks++; if (pc !== 8'h00) begin errors++;
            $display("FAIL reset_pc got=%h want=00", pc); end
        checks++; if (instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr got=%h want=00000000", instr); end
        checks++; if (mem_addr !== 8'h00) begin errors++;
            $display("FAIL reset_mem_addr got=%h want=00", mem_addr); end
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin errors++;
            $display("FAIL reset_release got req=%b addr=%h want req=1 addr=00",
                     mem_req, mem_addr); end
    endtask

    task automatic test_zero_wait();
        mem[0] = 8'h44; mem[1] = 8'h00; mem[2] = 8'h03; mem[3] = 8'h80;
        do_reset();
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            checks++; if (instr_valid !== (c == 4)) begin errors++;
                $display("FAIL zw_valid cycle=%0d got=%b want=%b", c, instr_valid, c == 4); end
            if (c < 4) begin
                checks++; if (mem_addr !== 8'(c) || mem_req !== 1'b1) begin errors++;
                    $display("FAIL zw_addr cycle=%0d got=%h req=%b want=%h req=1",
                             c, mem_addr, mem_req, 8'(c)); end
            end else begin
                checks++; if (instr !== 32'h80030044) begin errors++;
                    $display("FAIL zw_instr got=%h want=80030044", instr); end
            end
            tick();
        end
        checks++; if (mem_addr !== 8'h04 || instr_valid !== 1'b0 || pc !== 8'h04) begin errors++;
            $display("FAIL zw_next got addr=%h valid=%b pc=%h want addr=04 valid=0 pc=04",
                     mem_addr, instr_valid, pc); end
    endtask

    task automatic test_wait_states();
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            mem_ack = !(c == 2 || c == 3);
            checks++; if (instr_valid !== (c >= 6)) begin errors++;
                $display("FAIL ws_valid cycle=%0d got=%b want=%b", c, instr_valid, c >= 6); end
            if (c >= 2 && c <= 4) begin
                checks++; if (mem_addr !== 8'h02) begin errors++;
                    $display("FAIL ws_hold_addr cycle=%0d got=%h want=02", c, mem_addr); end
            end
            if (c == 6) begin
                checks++; if (instr !== 32'h80030044) begin errors++;
                    $display("FAIL ws_instr got=%h want=80030044", instr); end
            end
            tick();
        end
    endtask

    // Starts in HOLD at pc 0 with instr_ready low.
    task automatic test_backpressure();
        for (int c = 0; c < 10; c++) begin
            mem_ack = 1'($urandom_range(0, 1));
            checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b0 || pc !== 8'h00 ||
                          instr !== 32'h80030044) begin errors++;
                $display("FAIL bp_stable cycle=%0d got valid=%b req=%b pc=%h instr=%h want 1 0 00 80030044",
                         c, instr_valid, mem_req, pc, instr); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++; if (pc !== 8'h04 || mem_addr !== 8'h04 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL bp_release got pc=%h addr=%h valid=%b want 04 04 0",
                     pc, mem_addr, instr_valid); end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 8'($urandom);
        do_reset();
        mem_ack = 1'b1;
        tick();
        tick();
        checks++; if (mem_addr !== 8'h02) begin errors++;
            $display("FAIL rd_pre got=%h want=02", mem_addr); end
        pc_load = 1'b1;
        pc_next = 8'h40;
        tick();
        pc_load = 1'b0;
        checks++; if (mem_addr !== 8'h40 || pc !== 8'h40 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL rd_target got addr=%h pc=%h valid=%b want 40 40 0",
                     mem_addr, pc, instr_valid); end
        for (int c = 0; c < 4; c++) tick();
        checks++; if (instr_valid !== 1'b1 || instr !== word_at(8'h40)) begin errors++;
            $display("FAIL rd_instr got valid=%b instr=%h want 1 %h",
                     instr_valid, instr, word_at(8'h40)); end
    endtask

    // Redirect and handshake in the same HOLD cycle: the redirect wins.
    task automatic test_load_vs_ready();
        pc_load = 1'b1;
        pc_next = 8'h10;
        tick();
        pc_load = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (instr_valid !== 1'b1 || pc !== 8'h10) begin errors++;
            $display("FAIL lr_hold got valid=%b pc=%h want 1 10", instr_valid, pc); end
        pc_load     = 1'b1;
        pc_next     = 8'h20;
        instr_ready = 1'b1;
        tick();
        pc_load     = 1'b0;
        instr_ready = 1'b0;
        checks++; if (pc !== 8'h20 || mem_addr !== 8'h20 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL lr_priority got pc=%h addr=%h valid=%b want 20 20 0",
                     pc, mem_addr, instr_valid); end
    endtask

    // Random traffic against a model that tracks the PC and bytes collected.
    task automatic test_random();
        logic [7:0] exp_pc;
        int         got;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        exp_pc = 8'h00;
        got    = 0;
        for (int c = 0; c < 2000; c++) begin
            checks++; if (mem_req !== (got < 4 && !reset) || instr_valid !== (got == 4) ||
                          pc !== exp_pc) begin errors++;
                $display("FAIL rnd_ctrl cycle=%0d got req=%b valid=%b pc=%h want %b %b %h",
                         c, mem_req, instr_valid, pc, got < 4 && !reset, got == 4, exp_pc); end
            if (got < 4) begin
                checks++; if (mem_addr !== exp_pc + 8'(got)) begin errors++;
                    $display("FAIL rnd_addr cycle=%0d got=%h want=%h", c, mem_addr,
                             exp_pc + 8'(got)); end
            end else begin
                checks++; if (instr !== word_at(exp_pc)) begin errors++;
                    $display("FAIL rnd_instr cycle=%0d got=%h want=%h", c, instr,
                             word_at(exp_pc)); end
            end
            reset       = ($urandom_range(0, 99) == 0);
            mem_ack     = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            pc_load     = ($urandom_range(0, 19) == 0);
            pc_next     = 8'($urandom);
            tick();
            if (reset) begin
                exp_pc = 8'h00;
                got    = 0;
            end else if (pc_load) begin
                exp_pc = pc_next;
                got    = 0;
            end else if (got == 4) begin
                if (instr_ready) begin
                    exp_pc = exp_pc + 8'd4;
                    got    = 0;
                end
            end else if (mem_ack) begin
                got++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        mem[8'hFC] = 8'hA1; mem[8'hFD] = 8'hB2; mem[8'hFE] = 8'hC3; mem[8'hFF] = 8'hD4;
        b_reset       = 1'b1;
        b_mem_ack     = 1'b0;
        b_instr_ready = 1'b0;
        tick();
        b_reset   = 1'b0;
        b_mem_ack = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (b_mem_addr !== 8'hFC + 8'(c) || b_mem_req !== 1'b1) begin errors++;
                $display("FAIL wr_addr cycle=%0d got=%h req=%b want=%h req=1",
                         c, b_mem_addr, b_mem_req, 8'hFC + 8'(c)); end
            tick();
        end
        checks++; if (b_instr_valid !== 1'b1 || b_instr !== 32'hD4C3B2A1 || b_pc !== 8'hFC)
        begin errors++;
            $display("FAIL wr_instr got valid=%b instr=%h pc=%h want 1 d4c3b2a1 fc",
                     b_instr_valid, b_instr, b_pc); end
        b_instr_ready = 1'b1;
        tick();
        b_instr_ready = 1'b0;
        checks++; if (b_pc !== 8'h00 || b_mem_addr !== 8'h00) begin errors++;
            $display("FAIL wr_pc_wrap got pc=%h addr=%h want 00 00", b_pc, b_mem_addr); end
        tick();
        checks++; if (b_mem_addr !== 8'h01) begin errors++;
            $display("FAIL wr_fetch1 got=%h want=01", b_mem_addr); end
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        #1;
        checks++; if (b_mem_addr !== 8'hFC || b_instr_valid !== 1'b0 || b_pc !== 8'hFC ||
                      b_instr !== 32'h0 || b_mem_req !== 1'b1) begin errors++;
            $display("FAIL wr_reset got addr=%h valid=%b pc=%h instr=%h req=%b want fc 0 fc 0 1",
                     b_mem_addr, b_instr_valid, b_pc, b_instr, b_mem_req); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        b_reset       = 1'b1;
        b_mem_ack     = 1'b0;
        b_instr_ready = 1'b0;
        b_pc_load     = 1'b0;
        b_pc_next     = 8'h00;
        #2;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_backpressure();
        test_redirect();
        test_load_vs_ready();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream instruction-fetch stage of the multicycle 8-bit-datapath MIPS core. It holds the program counter, fetches each 32-bit instruction as four byte reads over a request/acknowledge memory port, and assembles the bytes into an instruction register. The assembled word goes to the instruction decoder under a valid/ready handshake. The controller redirects the PC through a load port for taken branches and jumps.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width of the PC and the memory port
- RESET_PC, 0, PC value after reset

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- mem_req  output  1  byte-read request
- mem_addr  output  ADDR_WIDTH  byte address of the current request
- mem_ack  input  1  read data valid on mem_rdata this cycle
- mem_rdata  input  8  read byte
- instr  output  32  assembled instruction, connected to the decoder instr input
- instr_valid  output  1  instr is complete and stable
- instr_ready  input  1  decoder/controller consumes instr this cycle
- pc_load  input  1  redirect request
- pc_next  input  ADDR_WIDTH  redirect target
- pc  output  ADDR_WIDTH  address of the byte 0 of instr

## Operation
- States: FETCH0, FETCH1, FETCH2, FETCH3, HOLD. Reset enters FETCH0.
- FETCHk (k=0..3):
  - mem_req=1, mem_addr=(pc+k) mod 2^ADDR_WIDTH.
  - On mem_ack, latch mem_rdata into instr[8k+7:8k] and advance to FETCH(k+1). FETCH3 advances to HOLD.
  - Without mem_ack, stay in the state with mem_addr stable.
- Byte order is little-endian: the byte at pc goes to instr[7:0], the byte at pc+3 goes to instr[31:24].
- HOLD:
  - mem_req=0, instr_valid=1, instr stable.
  - On instr_ready: pc <= pc+4 (mod 2^ADDR_WIDTH), next state FETCH0.
  - Without instr_ready, stay in HOLD indefinitely.
- pc_load (any state):
  - pc <= pc_next; next state FETCH0; instr_valid drops the next cycle.
  - Any partially assembled bytes are discarded.
  - A mem_ack in the same cycle is ignored.
  - A held instruction is dropped even when instr_ready is high in the same cycle, so no pc+4 increment occurs.
- Priority: reset > pc_load > instr_ready handshake > mem_ack.
- mem_ack while mem_req=0 (HOLD, reset) is ignored.
- instr bits not yet overwritten keep their previous values during FETCH0..FETCH3. Consumers use instr only while instr_valid=1.
- pc_next is used unaligned as given. No alignment check is made.

## Timing
- Reset values:
  - pc=RESET_PC, instr=32'h0, instr_valid=0, state FETCH0.
  - mem_req is forced 0 while reset is high.
  - mem_addr=RESET_PC.
- First cycle after reset deasserts: mem_req=1, mem_addr=RESET_PC.
- mem_req, mem_addr, instr, instr_valid and pc are functions of registered state only. There is no combinational path from mem_ack, instr_ready or pc_load to any output.
- Memory handshake:
  - Request is held until acknowledged.
  - mem_ack may arrive in the same cycle mem_req rises, so zero-wait memory is supported.
  - One byte is accepted per acknowledged cycle.
- Latency with zero-wait memory: FETCH0 at cycle t, instr_valid=1 at cycle t+4.
  - Back-to-back throughput is 5 cycles per instruction when instr_ready is tied high.
- Each memory wait cycle adds exactly one cycle of latency.
- Handshake at cycle t (instr_valid & instr_ready): instr_valid=0 and mem_req=1 with mem_addr=pc+4 at t+1.
- Redirect at cycle t: mem_addr=pc_next at t+1.
- Reset asserted mid-fetch: the state at the next edge equals the reset values, and the fetch restarts from RESET_PC.

## Test plan
- Zero-wait fetch: memory bytes at 0..3 = 44,00,03,80; instr_ready=1 → instr=32'h80030044, instr_valid high exactly at cycle 4 after reset release, then mem_addr=4.
- Wait states: mem_ack delayed 2 cycles on byte 2 → mem_addr holds 2 for 3 cycles; instr_valid high at cycle 6; assembled word correct.
- Backpressure: instr_ready=0 for 10 cycles in HOLD → instr, pc and instr_valid stable, mem_req=0; ready pulse → pc=4, mem_addr=4 next cycle.
- Redirect mid-fetch: pc_load=1, pc_next=8'h40 asserted during FETCH2 with mem_ack=1 → the byte is discarded; next cycle mem_addr=8'h40; resulting instr built only from bytes 40..43.
- Simultaneous pc_load and instr_ready in HOLD, pc=8'h10, pc_next=8'h20 → pc=8'h20 (not 8'h14); fetch starts at 8'h20.
- Wrap-around: RESET_PC=8'hFC → byte addresses FC,FD,FE,FF; after the handshake pc=8'h00. A synchronous reset pulse during FETCH1 restarts at mem_addr=8'hFC with instr_valid=0.
